infra_sensor_pio: RTL and testbench
===================================

Name: infra_sensor_pio

Overview:
- Parametrised Avalon-MM read/interrupt slave for the robot car's infrared line/obstacle sensors. Next generation of the single-bit sensor input port.
- Per channel, the block synchronises each asynchronous sensor line and debounces it.
- It detects edges on the debounced value, latches them in a write-1-to-clear capture register, and raises a maskable interrupt to the Nios II.
- Sits between the sensor pins and the Qsys interconnect.

Parameters:
- WIDTH, 4, number of sensor channels (1..32).
- DEBOUNCE_CYCLES, 16, consecutive clk cycles a new synchronised level must persist before it is accepted (>=1). Counter width is clog2(DEBOUNCE_CYCLES)+1.
- EDGE_TYPE, 2, edges captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- in_port  in  WIDTH  raw asynchronous sensor inputs
- readdata  out  32  registered Avalon read data
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset, asynchronous: sync stages, debounced value stable, all debounce counters, irq_mask, edge_capture and readdata are all 0.
  - irq = 0 because it is derived from registers.
  - Reset mid-debounce discards the partial count.
- Synchroniser: two flops per channel, giving sync2.
- Debounce, per channel i, each clk:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A level change on in_port held from before edge 1 appears on stable at edge 2+DEBOUNCE_CYCLES.
  - Any excursion shorter than DEBOUNCE_CYCLES cycles at sync2 is rejected with no stable change.
- Edge detect: evaluated on the same edge that stable[i] updates.
  - rise = update to 1; fall = update to 0.
  - Qualifying edge per EDGE_TYPE sets edge_capture[i] on that edge.
- Register map:
  - Read mux: addresses 0–3 as listed below; bits >= WIDTH read 0.
  - addr 0: stable, read-only; writes ignored.
  - addr 1: sync2, raw synchronised value, read-only, diagnostic.
  - addr 2: irq_mask, read/write. Write when chipselect & ~write_n; takes writedata[WIDTH-1:0].
  - addr 3: edge_capture, read / write-1-to-clear. Each writedata bit = 1 clears the corresponding bit.
- Read timing: readdata <= mux(address) every clk, with no read strobe.
  - Data is valid one cycle after address is presented (read latency 1).
- Simultaneous new edge and W1C clear on the same bit in the same cycle: set wins, bit stays 1.
- Write to irq_mask takes effect for irq on the next cycle.
- irq = |(edge_capture & irq_mask): combinational from registers, no extra latency.
  - irq stays asserted until software clears the capture bit or masks it.
- Post-reset, an input held high is seen as a rising edge after the debounce time and is captured; software clears it at init.

Test Plan:
WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=2 unless stated.
1. Reset: assert reset_n=0 mid-count with in_port=4'hF → readdata, irq, edge_capture, mask all 0. After release, hold in_port=4'hF → addr 0 reads 0x0000000F; stable changes at edge 6; readdata valid after edge 7.
2. Glitch rejection: in_port[1] 0→1 for 3 cycles then back to 0 → addr 0 stays 0x0, addr 3 stays 0x0, irq stays 0.
3. Edge and interrupt: write irq_mask=0x4; raise in_port[2] → edge_capture=0x4 and irq=1 at stable update. Write 0x4 to addr 3 → edge_capture=0, irq=0 next cycle.
4. Mask and clear semantics:
   - Edges on bits 0 and 3 with mask=0x1 → edge_capture=0x9, irq=1.
   - Write 0x1 to addr 3 → edge_capture=0x8, irq=0.
   - Write mask=0x8 → irq=1.
5. Set-wins collision: time a W1C of 0x2 on the same cycle as stable[1] updates → edge_capture[1] remains 1.
6. EDGE_TYPE=1 build: 0→1 on in_port[0] → no capture; then 1→0 → edge_capture=0x1. Write 0xFFFFFFFF to addr 0 → addr 0 unchanged.

Source files
------------

// File: rtl/infra_sensor_pio.sv
// Infrared sensor PIO: per-channel 2-flop sync, debounce, edge capture (W1C) and maskable level irq.
// Latency: in_port to stable is 2+DEBOUNCE_CYCLES clk; Avalon read data is registered (latency 1).
// Backpressure: none; the slave accepts every access with no wait states and reads carry no side effects.
module infra_sensor_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    // Upper writedata bits are only meaningful for wider builds; fold them away here.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign wr_en = chipselect & ~write_n;

    // Debounce: a new level must be seen on sync2 for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Edge select on the cycle stable updates; the capture set term is ORed last so it beats a W1C.
    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        if (EDGE_TYPE == 0) begin
            edge_set = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_set = fall;
        end else begin
            edge_set = rise | fall;
        end
        cap_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
        cap_d   = (cap_q & ~cap_clr) | edge_set;
        mask_d  = (wr_en && (address == 2'd2)) ? writedata[WIDTH-1:0] : mask_q;
    end

    // Read mux over the current register values; unused high bits read as zero.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[WIDTH-1:0] = sync2_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            default: readdata_d[WIDTH-1:0] = cap_q;
        endcase
    end

    // State registers; reset also discards any partial debounce count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_infra_sensor_pio.sv
// Bench for infra_sensor_pio: directed scenarios plus random traffic against a window-based reference model.
// Two builds share one bus: EDGE_TYPE=2 (u_any) and EDGE_TYPE=1 (u_fall), both DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_infra_sensor_pio;

    localparam int W = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [W-1:0] in_port = '0;
    logic [31:0] rd_a;
    logic [31:0] rd_f;
    logic        irq_a;
    logic        irq_f;

    int n_checks = 0;
    int n_pass   = 0;

    infra_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    infra_sensor_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last D sync2 samples all differ from the
    // accepted level. sync2 seen at a given edge is the in_port sampled two edges earlier.
    logic [W-1:0] m_stable;
    logic [W-1:0] m_cap  [2];
    logic [W-1:0] m_mask [2];
    logic [31:0]  m_rd   [2];
    logic [W-1:0] hist [$];
    logic [W-1:0] m_flip;
    logic [W-1:0] m_set;
    bit           m_diff;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stable = '0;
            for (int k = 0; k < 2; k++) begin
                m_cap[k]  = '0;
                m_mask[k] = '0;
                m_rd[k]   = 32'h0;
            end
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back('0);
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (address)
                    2'd0:    m_rd[k] = {28'h0, m_stable};
                    2'd1:    m_rd[k] = {28'h0, hist[hist.size()-2]};
                    2'd2:    m_rd[k] = {28'h0, m_mask[k]};
                    default: m_rd[k] = {28'h0, m_cap[k]};
                endcase
            end
            m_flip = '0;
            for (int ch = 0; ch < W; ch++) begin
                m_diff = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (hist[hist.size()-2-j][ch] == m_stable[ch]) m_diff = 1'b0;
                end
                m_flip[ch] = m_diff;
            end
            for (int k = 0; k < 2; k++) begin
                m_set = (k == 0) ? m_flip : (m_flip & m_stable);
                if (chipselect && !write_n && address == 2'd3) m_cap[k] = m_cap[k] & ~writedata[W-1:0];
                m_cap[k] = m_cap[k] | m_set;
                if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[W-1:0];
            end
            m_stable = m_stable ^ m_flip;
            hist.push_back(in_port);
            void'(hist.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        tick();
        bus_idle();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        in_port = 4'hF;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rd_a !== 32'h0 || irq_a !== 1'b0) $display("FAIL reset_any rd=%h irq=%b exp rd=0 irq=0", rd_a, irq_a);
        else n_pass++;
        n_checks++;
        if (rd_f !== 32'h0 || irq_f !== 1'b0) $display("FAIL reset_fall rd=%h irq=%b exp rd=0 irq=0", rd_f, irq_f);
        else n_pass++;
        tick();
        #1;
        reset_n = 1'b1;
        address = 2'd2;
        tick();
        n_checks++;
        if (rd_a !== 32'h0) $display("FAIL reset_mask got %h exp 0", rd_a);
        else n_pass++;
        address = 2'd3;
        tick();
        n_checks++;
        if (rd_a !== 32'h0) $display("FAIL reset_cap got %h exp 0", rd_a);
        else n_pass++;
        address = 2'd0;
        repeat (4) tick();
        n_checks++;
        if (rd_a !== 32'h0) $display("FAIL stable_early edge6 got %h exp 0", rd_a);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_a !== 32'hF || rd_a !== m_rd[0]) $display("FAIL stable_edge7 got %h exp %h model %h", rd_a, 32'hF, m_rd[0]);
        else n_pass++;
        address = 2'd3;
        tick();
        n_checks++;
        if (rd_a !== 32'hF || rd_f !== 32'h0 || irq_a !== 1'b0)
            $display("FAIL powerup_rise cap_any=%h cap_fall=%h irq=%b exp F 0 0", rd_a, rd_f, irq_a);
        else n_pass++;
        bus_write(2'd3, 32'hF);
    endtask

    task automatic test_glitch();
        in_port = 4'h0;
        repeat (D + 4) tick();
        bus_write(2'd3, 32'hF);
        in_port = 4'b0010;
        repeat (3) tick();
        in_port = 4'h0;
        address = 2'd0;
        repeat (10) tick();
        n_checks++;
        if (rd_a !== 32'h0 || rd_a !== m_rd[0]) $display("FAIL glitch_stable got %h exp 0", rd_a);
        else n_pass++;
        address = 2'd3;
        tick();
        n_checks++;
        if (rd_a !== 32'h0 || rd_f !== 32'h0 || irq_a !== 1'b0)
            $display("FAIL glitch_cap any=%h fall=%h irq=%b exp 0 0 0", rd_a, rd_f, irq_a);
        else n_pass++;
    endtask

    task automatic test_edge_irq();
        bus_write(2'd2, 32'h4);
        in_port = 4'b0100;
        repeat (5) tick();
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL irq_early got %b exp 0", irq_a);
        else n_pass++;
        tick();
        n_checks++;
        if (irq_a !== 1'b1 || irq_f !== 1'b0) $display("FAIL irq_on_update any=%b fall=%b exp 1 0", irq_a, irq_f);
        else n_pass++;
        address = 2'd3;
        tick();
        n_checks++;
        if (rd_a !== 32'h4) $display("FAIL edge_cap got %h exp 4", rd_a);
        else n_pass++;
        bus_write(2'd3, 32'h4);
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL irq_after_clear got %b exp 0", irq_a);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_a !== 32'h0 || rd_a !== m_rd[0]) $display("FAIL cap_after_clear got %h exp 0", rd_a);
        else n_pass++;
    endtask

    task automatic test_mask_clear();
        bus_write(2'd2, 32'h1);
        in_port = 4'b1101;
        repeat (D + 2) tick();
        address = 2'd3;
        tick();
        n_checks++;
        if (rd_a !== 32'h9 || irq_a !== 1'b1) $display("FAIL mask_cap got cap=%h irq=%b exp 9 1", rd_a, irq_a);
        else n_pass++;
        bus_write(2'd3, 32'h1);
        n_checks++;
        if (irq_a !== 1'b0) $display("FAIL masked_irq got %b exp 0", irq_a);
        else n_pass++;
        tick();
        n_checks++;
        if (rd_a !== 32'h8) $display("FAIL partial_clear got %h exp 8", rd_a);
        else n_pass++;
        bus_write(2'd2, 32'h8);
        n_checks++;
        if (irq_a !== 1'b1) $display("FAIL remask_irq got %b exp 1", irq_a);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        bus_write(2'd3, 32'hF);
        in_port = 4'b1111;
        repeat (5) tick();
        address    = 2'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h2;
        tick();
        bus_idle();
        tick();
        n_checks++;
        if (rd_a !== 32'h2 || rd_a !== m_rd[0]) $display("FAIL set_wins got %h exp 2", rd_a);
        else n_pass++;
        n_checks++;
        if (rd_f !== 32'h0) $display("FAIL set_wins_fall got %h exp 0", rd_f);
        else n_pass++;
    endtask

    task automatic test_falling_build();
        in_port = 4'h0;
        repeat (D + 4) tick();
        bus_write(2'd3, 32'hF);
        in_port = 4'h1;
        repeat (D + 4) tick();
        n_checks++;
        if (rd_f !== 32'h0 || rd_a !== 32'h1) $display("FAIL fall_no_rise fall=%h any=%h exp 0 1", rd_f, rd_a);
        else n_pass++;
        in_port = 4'h0;
        repeat (D + 4) tick();
        n_checks++;
        if (rd_f !== 32'h1 || rd_f !== m_rd[1]) $display("FAIL fall_capture got %h exp 1", rd_f);
        else n_pass++;
        in_port = 4'h6;
        repeat (D + 4) tick();
        bus_write(2'd0, 32'hFFFFFFFF);
        tick();
        n_checks++;
        if (rd_a !== 32'h6 || rd_f !== 32'h6) $display("FAIL ro_stable any=%h fall=%h exp 6 6", rd_a, rd_f);
        else n_pass++;
        address = 2'd2;
        tick();
        n_checks++;
        if (rd_a !== 32'h8 || rd_f !== 32'h8) $display("FAIL mask_kept any=%h fall=%h exp 8 8", rd_a, rd_f);
        else n_pass++;
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(4) == 0) in_port = W'($urandom);
            op = $urandom_range(7);
            bus_idle();
            address = 2'($urandom);
            case (op)
                0: begin address = 2'd2; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom; end
                1: begin address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom; end
                2: begin chipselect = 1'b1; write_n = 1'b1; writedata = $urandom; end
                3: begin chipselect = 1'b0; write_n = 1'b0; writedata = $urandom; end
                4: begin address = 2'd0; chipselect = 1'b1; write_n = 1'b0; writedata = $urandom; end
                default: ;
            endcase
            tick();
            n_checks++;
            if (rd_a !== m_rd[0] || irq_a !== |(m_cap[0] & m_mask[0]))
                $display("FAIL rand_any cyc=%0d rd=%h irq=%b exp rd=%h irq=%b", c, rd_a, irq_a, m_rd[0], |(m_cap[0] & m_mask[0]));
            else n_pass++;
            n_checks++;
            if (rd_f !== m_rd[1] || irq_f !== |(m_cap[1] & m_mask[1]))
                $display("FAIL rand_fall cyc=%0d rd=%h irq=%b exp rd=%h irq=%b", c, rd_f, irq_f, m_rd[1], |(m_cap[1] & m_mask[1]));
            else n_pass++;
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_edge_irq();
        test_mask_clear();
        test_set_wins();
        test_falling_build();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
